// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - three-way slot arbiter in front of the single-port SDRAM core
module sdram_arbiter #(
    parameter int SLOT_CYCLES    = 4,
    parameter int MAX_VID_STREAK = 4,
    parameter int AW             = 25
) (
    input  logic          F14M,
    input  logic          RESET_n,
    input  logic          dl_active,
    input  logic          dl_req,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_din,
    output logic          dl_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [7:0]    vid_dout,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic          cpu_ack,
    output logic [7:0]    cpu_dout,
    output logic [AW-1:0] sd_addr,
    output logic [7:0]    sd_din,
    output logic          sd_we,
    output logic          sd_oe,
    input  logic [7:0]    sd_dout,
    output logic [1:0]    grant,
    output logic          busy
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int SW = $clog2(MAX_VID_STREAK + 1);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(SLOT_CYCLES - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_VID_STREAK);

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_DL   = 2'd1;
    localparam logic [1:0] G_VID  = 2'd2;
    localparam logic [1:0] G_CPU  = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t         state;
    logic [CW-1:0]  slot_cnt;
    logic [SW-1:0]  streak;
    logic [1:0]     pick;

    // Winner for the next slot, from the live request levels; only consumed in IDLE
    always_comb begin
        pick = G_NONE;
        if (dl_req) begin
            pick = G_DL;
        end else if (!dl_active) begin
            if (cpu_req && streak == STREAK_MAX) begin
                pick = G_CPU;
            end else if (vid_req) begin
                pick = G_VID;
            end else if (cpu_req) begin
                pick = G_CPU;
            end
        end
    end

    // Slot sequencer: IDLE arbitrates, ACCESS holds the SDRAM strobes, DONE pulses the ack
    always_ff @(posedge F14M or negedge RESET_n) begin
        if (!RESET_n) begin
            state    <= IDLE;
            slot_cnt <= '0;
            streak   <= '0;
            grant    <= G_NONE;
            busy     <= 1'b0;
            dl_ack   <= 1'b0;
            vid_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            vid_dout <= 8'h00;
            cpu_dout <= 8'h00;
            sd_addr  <= '0;
            sd_din   <= 8'h00;
            sd_we    <= 1'b0;
            sd_oe    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // The streak only counts video wins that actually held off a waiting CPU
                    if (pick == G_CPU || !cpu_req) begin
                        streak <= '0;
                    end else if (pick == G_VID && streak != STREAK_MAX) begin
                        streak <= streak + 1'b1;
                    end
                    if (pick != G_NONE) begin
                        state    <= ACCESS;
                        grant    <= pick;
                        busy     <= 1'b1;
                        slot_cnt <= CNT_LOAD;
                        case (pick)
                            G_DL: begin
                                sd_addr <= dl_addr;
                                sd_din  <= dl_din;
                                sd_we   <= 1'b1;
                                sd_oe   <= 1'b0;
                            end
                            G_VID: begin
                                sd_addr <= vid_addr;
                                sd_din  <= 8'h00;
                                sd_we   <= 1'b0;
                                sd_oe   <= 1'b1;
                            end
                            default: begin
                                sd_addr <= cpu_addr;
                                sd_din  <= cpu_din;
                                sd_we   <= cpu_we;
                                sd_oe   <= !cpu_we;
                            end
                        endcase
                    end
                end
                ACCESS: begin
                    if (slot_cnt == '0) begin
                        state <= DONE;
                        sd_we <= 1'b0;
                        sd_oe <= 1'b0;
                        if (grant == G_VID) begin
                            vid_dout <= sd_dout;
                        end
                        if (grant == G_CPU && sd_oe) begin
                            cpu_dout <= sd_dout;
                        end
                        dl_ack  <= (grant == G_DL);
                        vid_ack <= (grant == G_VID);
                        cpu_ack <= (grant == G_CPU);
                    end else begin
                        slot_cnt <= slot_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    grant   <= G_NONE;
                    busy    <= 1'b0;
                    dl_ack  <= 1'b0;
                    vid_ack <= 1'b0;
                    cpu_ack <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter
module tb_sdram_arbiter;

    localparam int S  = 4;
    localparam int M  = 4;
    localparam int AW = 25;

    logic          F14M = 1'b0;
    logic          RESET_n;
    logic          dl_active, dl_req, vid_req, cpu_req, cpu_we;
    logic [AW-1:0] dl_addr, vid_addr, cpu_addr;
    logic [7:0]    dl_din, cpu_din;
    logic          dl_ack, vid_ack, cpu_ack;
    logic [7:0]    vid_dout, cpu_dout;
    logic [AW-1:0] sd_addr;
    logic [7:0]    sd_din, sd_dout;
    logic          sd_we, sd_oe;
    logic [1:0]    grant;
    logic          busy;

    sdram_arbiter #(.SLOT_CYCLES(S), .MAX_VID_STREAK(M), .AW(AW)) dut (
        .F14M(F14M), .RESET_n(RESET_n), .dl_active(dl_active),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_oe(sd_oe), .sd_dout(sd_dout),
        .grant(grant), .busy(busy)
    );

    always #5 F14M = ~F14M;

    logic [7:0] rd_mem [256];
    assign sd_dout = rd_mem[sd_addr[7:0]];

    int errors = 0;
    int checks = 0;
    int streak_m;
    logic [7:0] exp_vid, exp_cpu;
    int prob [3];
    bit rand_mode = 0;
    int n_ack [3] = '{0, 0, 0};

    // Count every ack pulse seen on the bus
    always @(negedge F14M) begin
        if (dl_ack)  n_ack[0] = n_ack[0] + 1;
        if (vid_ack) n_ack[1] = n_ack[1] + 1;
        if (cpu_ack) n_ack[2] = n_ack[2] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        streak_m = 0;
        exp_vid  = 8'h00;
        exp_cpu  = 8'h00;
    endtask

    // Arbitration rules: dl always first; under dl_active nothing else; a CPU kept waiting
    // behind M video slots jumps the queue once.
    function automatic int arbitrate();
        int w;
        if (dl_req)                         w = 1;
        else if (dl_active)                 w = 0;
        else if (cpu_req && streak_m >= M)  w = 3;
        else if (vid_req)                   w = 2;
        else if (cpu_req)                   w = 3;
        else                                w = 0;
        if (w == 3 || !cpu_req)  streak_m = 0;
        else if (w == 2)         streak_m = (streak_m + 1 > M) ? M : streak_m + 1;
        return w;
    endfunction

    task automatic new_req(input int who);
        case (who)
            0: begin dl_req = 1'b1; dl_addr = AW'($urandom); dl_din = 8'($urandom); end
            1: begin vid_req = 1'b1; vid_addr = AW'($urandom); end
            default: begin
                cpu_req = 1'b1; cpu_addr = AW'($urandom); cpu_din = 8'($urandom);
                cpu_we = 1'($urandom_range(0, 1));
            end
        endcase
    endtask

    task automatic do_reset();
        dl_req = 0; vid_req = 0; cpu_req = 0; dl_active = 0;
        RESET_n = 1'b0;
        repeat (2) @(negedge F14M);
        model_reset();
        RESET_n = 1'b1;
    endtask

    // One slot starting from an IDLE negedge with the request levels already driven
    task automatic run_slot(output int w, output int g);
        logic [AW-1:0] ea;
        logic [7:0]    ed;
        logic          ewe;
        ea = '0; ed = 8'h00; ewe = 1'b0;
        w = arbitrate();
        case (w)
            1: begin ea = dl_addr;  ed = dl_din;  ewe = 1'b1;   end
            2: begin ea = vid_addr; ewe = 1'b0;                 end
            3: begin ea = cpu_addr; ed = cpu_din; ewe = cpu_we; end
            default: ;
        endcase
        g = 0;
        if (w == 0) begin
            @(negedge F14M);
            chk("idle_grant", 32'(grant), 0);
            return;
        end
        for (int c = 0; c < S; c++) begin
            @(negedge F14M);
            if (c == 0) g = int'(grant);
            chk("acc_grant", 32'(grant), 32'(w));
            chk("acc_busy", 32'(busy), 1);
            chk("acc_addr", 32'(sd_addr), 32'(ea));
            chk("acc_we", 32'(sd_we), 32'(ewe));
            chk("acc_oe", 32'(sd_oe), 32'(!ewe));
            if (ewe) chk("acc_din", 32'(sd_din), 32'(ed));
            chk("acc_noack", 32'({dl_ack, vid_ack, cpu_ack}), 0);
            if (rand_mode && c == 1 && $urandom_range(0, 3) == 0)
                dl_active = 1'($urandom_range(0, 1));
        end
        if (w == 2)           exp_vid = rd_mem[ea[7:0]];
        if (w == 3 && !ewe)   exp_cpu = rd_mem[ea[7:0]];
        @(negedge F14M);
        chk("done_acks", 32'({dl_ack, vid_ack, cpu_ack}), 32'({w == 1, w == 2, w == 3}));
        chk("done_grant", 32'(grant), 32'(w));
        chk("done_busy", 32'(busy), 1);
        chk("done_strobes", 32'({sd_we, sd_oe}), 0);
        chk("done_vid_dout", 32'(vid_dout), 32'(exp_vid));
        chk("done_cpu_dout", 32'(cpu_dout), 32'(exp_cpu));
        @(negedge F14M);
        chk("idle_acks", 32'({dl_ack, vid_ack, cpu_ack}), 0);
        chk("idle_grant", 32'(grant), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_vid_dout", 32'(vid_dout), 32'(exp_vid));
        chk("idle_cpu_dout", 32'(cpu_dout), 32'(exp_cpu));
    endtask

    // Handshake: owner drops its request, then requesters (re)raise per their probability
    task automatic next_reqs(input int w);
        if (w == 1) dl_req = 0;
        if (w == 2) vid_req = 0;
        if (w == 3) cpu_req = 0;
        for (int i = 0; i < 3; i++) begin
            logic cur;
            cur = (i == 0) ? dl_req : (i == 1) ? vid_req : cpu_req;
            if (!cur && $urandom_range(1, 100) <= prob[i]) new_req(i);
            else if (cur && rand_mode && $urandom_range(0, 1) == 1) new_req(i);
        end
        if (rand_mode) begin
            dl_active = ($urandom_range(0, 9) == 0);
            if (!(dl_req || (!dl_active && (vid_req || cpu_req))))
                new_req(dl_active ? 0 : $urandom_range(0, 2));
        end
    endtask

    int w, g;
    int base [3];
    int exp_seq [10] = '{2, 2, 2, 2, 3, 2, 2, 2, 2, 3};

    initial begin
        for (int i = 0; i < 256; i++) rd_mem[i] = 8'($urandom);
        rd_mem[8'h23] = 8'hA5;
        prob = '{0, 0, 0};
        dl_active = 0; dl_req = 0; vid_req = 0; cpu_req = 0; cpu_we = 0;
        dl_addr = '0; vid_addr = '0; cpu_addr = '0; dl_din = 0; cpu_din = 0;
        RESET_n = 1'b0;

        // Reset held with every request high
        new_req(0); new_req(1); new_req(2);
        repeat (3) @(negedge F14M);
        chk("rst_acks", 32'({dl_ack, vid_ack, cpu_ack}), 0);
        chk("rst_strobes", 32'({sd_we, sd_oe}), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sd_addr", 32'(sd_addr), 0);
        chk("rst_douts", 32'({vid_dout, cpu_dout}), 0);
        model_reset();
        RESET_n = 1'b1;
        run_slot(w, g);
        chk("rst_first_dl", 32'(g), 1);

        // CPU read then CPU write
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = AW'(25'h0123); cpu_din = 8'h00;
        run_slot(w, g);
        chk("cpu_rd_grant", 32'(g), 3);
        chk("cpu_rd_data", 32'(cpu_dout), 32'h A5);
        next_reqs(w);
        repeat (3) @(negedge F14M);
        chk("cpu_rd_hold", 32'(cpu_dout), 32'h A5);
        cpu_req = 1; cpu_we = 1; cpu_addr = AW'(25'h4000); cpu_din = 8'h3C;
        base = n_ack;
        run_slot(w, g);
        chk("cpu_wr_grant", 32'(g), 3);
        chk("cpu_wr_dout_kept", 32'(cpu_dout), 32'h A5);
        next_reqs(w);
        repeat (3) @(negedge F14M);
        chk("cpu_wr_one_ack", 32'(n_ack[2] - base[2]), 1);

        // Video streak versus a waiting CPU
        do_reset();
        prob = '{0, 100, 100};
        new_req(1); new_req(2);
        for (int i = 0; i < 10; i++) begin
            run_slot(w, g);
            chk($sformatf("starve_seq%0d", i), 32'(g), 32'(exp_seq[i]));
            next_reqs(w);
        end

        // Download exclusivity, then the held vid/cpu requests drain
        do_reset();
        prob = '{100, 0, 0};
        dl_active = 1;
        new_req(0); new_req(1); new_req(2);
        base = n_ack;
        for (int i = 0; i < 3; i++) begin
            run_slot(w, g);
            chk("dl_only", 32'(g), 1);
            if (i == 2) prob[0] = 0;
            next_reqs(w);
        end
        dl_active = 0;
        run_slot(w, g);
        chk("dl_after_vid", 32'(g), 2);
        next_reqs(w);
        run_slot(w, g);
        chk("dl_after_cpu", 32'(g), 3);
        next_reqs(w);
        repeat (4) @(negedge F14M);
        chk("dl_ack_count", 32'(n_ack[0] - base[0]), 3);
        chk("vid_ack_count", 32'(n_ack[1] - base[1]), 1);
        chk("cpu_ack_count", 32'(n_ack[2] - base[2]), 1);

        // Reset during cycle 2 of a CPU read
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = AW'(25'h0123);
        base = n_ack;
        @(negedge F14M);
        @(negedge F14M);
        chk("mid_oe_before", 32'(sd_oe), 1);
        RESET_n = 1'b0;
        #1;
        chk("mid_oe_dropped", 32'(sd_oe), 0);
        chk("mid_grant", 32'(grant), 0);
        chk("mid_busy", 32'(busy), 0);
        repeat (2) @(negedge F14M);
        chk("mid_no_ack", 32'(n_ack[2] - base[2]), 0);
        model_reset();
        RESET_n = 1'b1;
        run_slot(w, g);
        chk("mid_regrant_cpu", 32'(g), 3);
        chk("mid_data", 32'(cpu_dout), 32'h A5);
        next_reqs(w);

        // Randomized contention
        do_reset();
        rand_mode = 1;
        prob = '{30, 70, 70};
        next_reqs(0);
        for (int i = 0; i < 150; i++) begin
            run_slot(w, g);
            next_reqs(w);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single-port SDRAM core between three requesters: ROM/file download (data_io), video fetch (VTL chip) and CPU memory access.
- Replaces the static download/VTL mux in the top level. It sequences one access at a time as a fixed-length slot on the F14M domain.
- Fixed priority: download > video > CPU, with a CPU anti-starvation guard.

Parameters:
- SLOT_CYCLES, 4, F14M cycles sd_* is held per access; must be ≥1.
- MAX_VID_STREAK, 4, consecutive video grants allowed while cpu_req is pending before the CPU is forced in; must be ≥1.
- AW, 25, SDRAM byte address width.

Ports:
- F14M  in  1  system clock.
- RESET_n  in  1  asynchronous active-low reset.
- dl_active  in  1  download in progress (data_io downloading); when high, only dl is granted.
- dl_req  in  1  download write request (level).
- dl_addr  in  AW  download address.
- dl_din  in  8  download write data.
- dl_ack  out  1  one-cycle completion pulse.
- vid_req  in  1  video read request (level).
- vid_addr  in  AW  video read address.
- vid_ack  out  1  one-cycle completion pulse.
- vid_dout  out  8  video read data, valid with vid_ack, held until next video completion.
- cpu_req  in  1  CPU request (level).
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  AW  CPU address.
- cpu_din  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_dout  out  8  CPU read data, valid with cpu_ack, held until next CPU read completion.
- sd_addr  out  AW  to sdram addr.
- sd_din  out  8  to sdram din.
- sd_we  out  1  to sdram we.
- sd_oe  out  1  to sdram oe.
- sd_dout  in  8  from sdram dout.
- grant  out  2  0=none, 1=dl, 2=vid, 3=cpu; current owner.
- busy  out  1  high in ACCESS and DONE.

Behaviour:
- Reset (async, RESET_n=0):
  - state=IDLE; grant=0; busy=0.
  - All acks=0; sd_we=sd_oe=0; sd_addr=0; sd_din=0.
  - vid_dout=cpu_dout=0x00; streak counter=0; slot counter=0.
  - Reset asserted mid-slot aborts the slot immediately; no ack is issued.
- All outputs are registered. No combinational path from any req to any sd_* output.
- FSM states:
  - IDLE: arbitrate on the current request levels. Winner → ACCESS. Latch the winner's addr/din/we into sd_* and set grant. Slot counter loads SLOT_CYCLES-1. No request → stay in IDLE.
  - ACCESS:
    - sd_addr/sd_din are held stable; sd_we=1 for a write, sd_oe=1 for a read (never both).
    - The counter decrements each cycle.
    - On the cycle the counter equals 0, capture sd_dout into vid_dout (video) or cpu_dout (CPU read) → DONE.
    - sd_we/sd_oe drop to 0 on entering DONE.
  - DONE: the owner's ack=1 for exactly this cycle; grant stays → IDLE, where grant becomes 0.
- Timing:
  - A request seen in IDLE at edge n drives sd_* during cycles n+1..n+SLOT_CYCLES; ack is at cycle n+SLOT_CYCLES+1.
  - Slot period is SLOT_CYCLES+2 cycles.
- Handshake:
  - req is held high until ack is seen. The requester deasserts req (or presents a new request) in the cycle after ack.
  - A req still high in the DONE cycle is not re-arbitrated in DONE; arbitration happens only in IDLE.
  - Address/data changes while a request is not yet granted are permitted; values are sampled in IDLE at grant.
- Arbitration in IDLE:
  - dl_active=1: only dl_req is eligible; vid/cpu requests stay pending with no ack.
  - dl_active=0: dl_req > vid_req > cpu_req. Exception: if streak==MAX_VID_STREAK and cpu_req=1, the CPU wins over video (a dl_req still beats it).
  - Download accesses are always writes (sd_we=1). Video accesses are always reads.
- Streak counter:
  - +1 (saturating at MAX_VID_STREAK) on each video grant while cpu_req=1.
  - Cleared on a CPU grant or when cpu_req=0 in IDLE.
- dl_active changing mid-slot does not affect the slot in progress; it applies at the next IDLE.
- Simultaneous requests from all three: one grant only; the others wait.

Test Plan:
- Reset: hold RESET_n=0 with all reqs=1 → all acks 0, sd_we=sd_oe=0, grant=0; release → dl granted first (grant=1).
- CPU read, SLOT_CYCLES=4: cpu_req=1, cpu_we=0, cpu_addr=0x0123, sdram model returns 0xA5 → sd_oe high exactly 4 cycles with sd_addr=0x0123; cpu_ack pulse at cycle 5 after grant; cpu_dout=0xA5, held thereafter.
- CPU write: cpu_we=1, cpu_din=0x3C, cpu_addr=0x4000 → sd_we=1 for 4 cycles with sd_din=0x3C, sd_oe=0, cpu_ack once.
- Starvation: vid_req and cpu_req both held high, MAX_VID_STREAK=4 → grant sequence vid,vid,vid,vid,cpu,vid,…
- Download: dl_active=1 with dl_req, vid_req, cpu_req all high → only dl slots occur. Drop dl_active → vid then cpu are serviced; no lost or duplicate acks.
- Mid-slot reset: assert RESET_n=0 during cycle 2 of a CPU read → sd_oe drops immediately, no cpu_ack. After release, re-arbitration starts from IDLE.
